// File: rtl/rx_pkt_arb_pkg.sv
// rx_pkt_arb_pkg: shared types and width defaults for rx_pkt_arb and rx_filter
// Contents: FSM state encoding, source-index type, DATA_W/MOD_W defaults.
package rx_pkt_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int MOD_W_DEF  = 2;

    typedef enum logic [1:0] {IDLE, PASS, ABORT, FLUSH} state_t;

    typedef logic src_t;
endpackage

// File: rtl/rx_pkt_arb_mux.sv
// rx_pkt_arb_mux: combinational 2:1 selection of one source stream by sel
// Ports: sel picks s1_* when 1, s0_* when 0; m_* carry the selected
// {din, sop, eop, vld, mod, err}.
module rx_pkt_arb_mux
    import rx_pkt_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MOD_W  = MOD_W_DEF
) (
    input  src_t              sel,
    input  logic [DATA_W-1:0] s0_din,
    input  logic              s0_din_sop,
    input  logic              s0_din_eop,
    input  logic              s0_din_vld,
    input  logic [MOD_W-1:0]  s0_din_mod,
    input  logic              s0_din_err,
    input  logic [DATA_W-1:0] s1_din,
    input  logic              s1_din_sop,
    input  logic              s1_din_eop,
    input  logic              s1_din_vld,
    input  logic [MOD_W-1:0]  s1_din_mod,
    input  logic              s1_din_err,
    output logic [DATA_W-1:0] m_din,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_vld,
    output logic [MOD_W-1:0]  m_mod,
    output logic              m_err
);
    assign m_din = sel ? s1_din     : s0_din;
    assign m_sop = sel ? s1_din_sop : s0_din_sop;
    assign m_eop = sel ? s1_din_eop : s0_din_eop;
    assign m_vld = sel ? s1_din_vld : s0_din_vld;
    assign m_mod = sel ? s1_din_mod : s0_din_mod;
    assign m_err = sel ? s1_din_err : s0_din_err;
endmodule

// File: rtl/rx_pkt_arb.sv
// rx_pkt_arb: two-source round-robin packet arbiter feeding rx_filter
// Ports: clk, rst (async, active-high); s0_*/s1_* source streams with
// sN_din_rdy backpressure; dout_* merged stream qualified by dout_rdy;
// grant = current/last granted source; drop_cnt = saturating discard count.
module rx_pkt_arb
    import rx_pkt_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MOD_W   = MOD_W_DEF,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_din,
    input  logic              s0_din_sop,
    input  logic              s0_din_eop,
    input  logic              s0_din_vld,
    input  logic              s0_din_err,
    input  logic [MOD_W-1:0]  s0_din_mod,
    output logic              s0_din_rdy,
    input  logic [DATA_W-1:0] s1_din,
    input  logic              s1_din_sop,
    input  logic              s1_din_eop,
    input  logic              s1_din_vld,
    input  logic              s1_din_err,
    input  logic [MOD_W-1:0]  s1_din_mod,
    output logic              s1_din_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              dout_vld,
    output logic              dout_err,
    output logic [MOD_W-1:0]  dout_mod,
    input  logic              dout_rdy,
    output logic              grant,
    output logic [CNT_W-1:0]  drop_cnt
);
    state_t            state, state_nxt;
    src_t              grant_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              first, first_nxt;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;
    logic              s0_rdy_c, s1_rdy_c, rdy_g;
    logic              req0, req1, trunc;
    logic [DATA_W-1:0] m_din;
    logic              m_sop, m_eop, m_vld, m_err;
    logic [MOD_W-1:0]  m_mod;

    rx_pkt_arb_mux #(.DATA_W(DATA_W), .MOD_W(MOD_W)) u_mux (
        .sel       (grant),
        .s0_din    (s0_din),
        .s0_din_sop(s0_din_sop),
        .s0_din_eop(s0_din_eop),
        .s0_din_vld(s0_din_vld),
        .s0_din_mod(s0_din_mod),
        .s0_din_err(s0_din_err),
        .s1_din    (s1_din),
        .s1_din_sop(s1_din_sop),
        .s1_din_eop(s1_din_eop),
        .s1_din_vld(s1_din_vld),
        .s1_din_mod(s1_din_mod),
        .s1_din_err(s1_din_err),
        .m_din     (m_din),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .m_vld     (m_vld),
        .m_mod     (m_mod),
        .m_err     (m_err)
    );

    assign req0  = s0_din_vld && s0_din_sop;
    assign req1  = s1_din_vld && s1_din_sop;
    // a fresh sop after the first word means the source restarted mid-packet
    assign trunc = m_vld && m_sop && !first;

    // gate with rst so neither source sees ready while reset is held
    assign s0_din_rdy = s0_rdy_c && !rst;
    assign s1_din_rdy = s1_rdy_c && !rst;

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        to_nxt    = to_cnt;
        first_nxt = first;
        drop_inc  = 2'd0;
        rdy_g     = 1'b0;
        s0_rdy_c  = 1'b0;
        s1_rdy_c  = 1'b0;
        dout      = '0;
        dout_sop  = 1'b0;
        dout_eop  = 1'b0;
        dout_vld  = 1'b0;
        dout_err  = 1'b0;
        dout_mod  = '0;
        unique case (state)
            IDLE: begin
                s0_rdy_c = s0_din_vld && !s0_din_sop;
                s1_rdy_c = s1_din_vld && !s1_din_sop;
                drop_inc = {1'b0, s0_rdy_c} + {1'b0, s1_rdy_c};
                if (req0 || req1) begin
                    grant_nxt = (req0 && req1) ? ~grant : req1;
                    state_nxt = PASS;
                    to_nxt    = '0;
                    first_nxt = 1'b1;
                end
            end
            PASS: begin
                dout     = m_din;
                dout_sop = m_sop;
                dout_eop = m_eop;
                dout_err = m_err;
                dout_mod = m_mod;
                dout_vld = m_vld && !trunc;
                rdy_g    = dout_rdy && !trunc;
                s0_rdy_c = rdy_g && !grant;
                s1_rdy_c = rdy_g && grant;
                if (trunc)
                    state_nxt = ABORT;
                else if (m_vld) begin
                    if (dout_rdy) begin
                        to_nxt    = '0;
                        first_nxt = 1'b0;
                        state_nxt = m_eop ? IDLE : PASS;
                    end
                end
                // abort on the cycle the counter would reach TIMEOUT-1
                else if (to_cnt == TO_W'(TIMEOUT - 2))
                    state_nxt = ABORT;
                else
                    to_nxt = to_cnt + 1'b1;
            end
            ABORT: begin
                dout_vld  = 1'b1;
                dout_eop  = 1'b1;
                dout_err  = 1'b1;
                state_nxt = dout_rdy ? FLUSH : ABORT;
            end
            FLUSH: begin
                rdy_g    = !m_sop;
                s0_rdy_c = rdy_g && !grant;
                s1_rdy_c = rdy_g && grant;
                if (m_vld && m_sop)
                    state_nxt = IDLE;
                else if (m_vld) begin
                    drop_inc  = 2'd1;
                    state_nxt = m_eop ? IDLE : FLUSH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b1;
            to_cnt   <= '0;
            first    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            to_cnt   <= to_nxt;
            first    <= first_nxt;
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_rx_pkt_arb.sv
// tb_rx_pkt_arb: scoreboard bench for rx_pkt_arb
module tb_rx_pkt_arb;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  mod;
        logic        err;
    } wd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_din, s1_din, dout;
    logic        s0_din_sop, s0_din_eop, s0_din_vld, s0_din_err, s0_din_rdy;
    logic        s1_din_sop, s1_din_eop, s1_din_vld, s1_din_err, s1_din_rdy;
    logic [1:0]  s0_din_mod, s1_din_mod, dout_mod;
    logic        dout_sop, dout_eop, dout_vld, dout_err, dout_rdy, grant;
    logic [CNT_W-1:0] drop_cnt;

    wd_t exp_q[$], obs_q[$];
    int  obs_cyc[$];
    int  cyc = 0, n_out = 0, total = 0, bad = 0, exp_drop = 0;
    logic kill = 1'b0;

    rx_pkt_arb #(.DATA_W(32), .MOD_W(2), .TIMEOUT(TIMEOUT), .TO_W(7), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s0_din(s0_din), .s0_din_sop(s0_din_sop), .s0_din_eop(s0_din_eop),
        .s0_din_vld(s0_din_vld), .s0_din_err(s0_din_err), .s0_din_mod(s0_din_mod),
        .s0_din_rdy(s0_din_rdy),
        .s1_din(s1_din), .s1_din_sop(s1_din_sop), .s1_din_eop(s1_din_eop),
        .s1_din_vld(s1_din_vld), .s1_din_err(s1_din_err), .s1_din_mod(s1_din_mod),
        .s1_din_rdy(s1_din_rdy),
        .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld),
        .dout_err(dout_err), .dout_mod(dout_mod), .dout_rdy(dout_rdy),
        .grant(grant), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && dout_vld && dout_rdy) begin
            obs_q.push_back({dout, dout_sop, dout_eop, dout_mod, dout_err});
            obs_cyc.push_back(cyc);
            n_out <= n_out + 1;
        end
    end

    task automatic drive(input int src, input logic v, input logic s, input logic e,
                         input logic [1:0] m, input logic [31:0] d);
        if (src == 0) begin
            s0_din = d; s0_din_vld = v; s0_din_sop = s; s0_din_eop = e; s0_din_mod = m; s0_din_err = 1'b0;
        end else begin
            s1_din = d; s1_din_vld = v; s1_din_sop = s; s1_din_eop = e; s1_din_mod = m; s1_din_err = 1'b0;
        end
    endtask

    // presents n words with valid/ready handshake; optional stall after word gap_at
    task automatic send(input int src, input int n, input logic [31:0] base, input logic [31:0] step,
                        input logic [1:0] mod, input logic sop_first, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            logic ok;
            ok = 1'b0;
            drive(src, 1'b1, sop_first && i == 0, i == n - 1, (i == n - 1) ? mod : 2'd0, base + step * 32'(i));
            for (int k = 0; k < 300 && !ok && !kill; k++) begin
                @(negedge clk);
                ok = (src == 0) ? s0_din_rdy : s1_din_rdy;
                @(posedge clk);
                #1;
            end
            if (kill) break;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL send_handshake src=%0d word=%0d got rdy=0 need rdy=1 within 300 cycles", src, i);
                break;
            end
            if (i == gap_at) begin
                drive(src, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drive(src, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    function automatic void push_pkt(input int n, input logic [31:0] base, input logic [31:0] step,
                                     input logic [1:0] mod);
        for (int i = 0; i < n; i++)
            exp_q.push_back({base + step * 32'(i), i == 0, i == n - 1, (i == n - 1) ? mod : 2'd0, 1'b0});
    endfunction

    task automatic wait_out(input int target);
        for (int k = 0; k < 300 && n_out < target; k++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (n_out < target) begin
            bad++;
            $display("FAIL wait_out got=%0d words need=%0d", n_out, target);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wd_t e, o;
        rst = 1'b1;
        dout_rdy = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h5);
        #1;
        e = '0;
        o = {dout, dout_sop, dout_eop, dout_mod, dout_err};
        total++;
        if (o !== e || dout_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_dout got=%h vld=%b need=%h vld=0", o, dout_vld, e);
        end
        total++;
        if ({s0_din_rdy, s1_din_rdy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_rdy got=%b need=00", {s0_din_rdy, s1_din_rdy});
        end
        total++;
        if (grant !== 1'b1 || drop_cnt !== '0) begin
            bad++;
            $display("FAIL reset_regs got grant=%b drop=%0d need grant=1 drop=0", grant, drop_cnt);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int s;
        wd_t e, o;
        s = cyc;
        push_pkt(5, 32'hffff0000, 32'd0, 2'd2);
        send(0, 5, 32'hffff0000, 32'd0, 2'd2, 1'b1, -1, 0);
        settle();
        total++;
        if (obs_cyc.size() == 0 || obs_cyc[0] != s + 1) begin
            bad++;
            $display("FAIL single_latency got first cyc=%0d need=%0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, s + 1);
        end
        total++;
        if (grant !== 1'b0 || drop_cnt !== CNT_W'(exp_drop)) begin
            bad++;
            $display("FAIL single_regs got grant=%b drop=%0d need grant=0 drop=%0d", grant, drop_cnt, exp_drop);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single_count got=%0d need=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single_word got=%h need=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_round_robin();
        wd_t e, o;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_pkt(3, 32'h100, 32'd1, 2'd1);
        push_pkt(3, 32'h200, 32'd1, 2'd2);
        fork
            send(0, 3, 32'h100, 32'd1, 2'd1, 1'b1, -1, 0);
            send(1, 3, 32'h200, 32'd1, 2'd2, 1'b1, -1, 0);
        join
        push_pkt(2, 32'h180, 32'd1, 2'd0);
        send(0, 2, 32'h180, 32'd1, 2'd0, 1'b1, -1, 0);
        push_pkt(3, 32'h280, 32'd1, 2'd3);
        push_pkt(3, 32'h1c0, 32'd1, 2'd1);
        fork
            send(0, 3, 32'h1c0, 32'd1, 2'd1, 1'b1, -1, 0);
            send(1, 3, 32'h280, 32'd1, 2'd3, 1'b1, -1, 0);
        join
        settle();
        total++;
        if (grant !== 1'b0) begin
            bad++;
            $display("FAIL rr_grant got=%b need=0", grant);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rr_count got=%0d need=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rr_word got=%h need=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_backpressure();
        wd_t e, o;
        int st;
        st = n_out;
        push_pkt(4, 32'h300, 32'd1, 2'd3);
        fork
            send(1, 4, 32'h300, 32'd1, 2'd3, 1'b1, -1, 0);
            begin
                wait_out(st + 2);
                @(posedge clk);
                #1;
                dout_rdy = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    total++;
                    if (s1_din_rdy !== 1'b0 || dout_vld !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold cycle=%0d got rdy=%b vld=%b need rdy=0 vld=1", k, s1_din_rdy, dout_vld);
                    end
                    @(posedge clk);
                    #1;
                end
                dout_rdy = 1'b1;
            end
        join
        settle();
        total++;
        if (grant !== 1'b1) begin
            bad++;
            $display("FAIL stall_grant got=%b need=1", grant);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count got=%0d need=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_word got=%h need=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_timeout();
        wd_t e, o;
        int gap;
        exp_q.push_back({32'h400, 1'b1, 1'b0, 2'd0, 1'b0});
        exp_q.push_back({32'h401, 1'b0, 1'b0, 2'd0, 1'b0});
        exp_q.push_back({32'h0,   1'b0, 1'b1, 2'd0, 1'b1});
        send(0, 5, 32'h400, 32'd1, 2'd1, 1'b1, 1, TIMEOUT);
        exp_drop += 3;
        settle();
        gap = (obs_cyc.size() >= 3) ? obs_cyc[2] - obs_cyc[1] : -1;
        total++;
        if (gap != TIMEOUT) begin
            bad++;
            $display("FAIL timeout_cycle got=%0d need=%0d", gap, TIMEOUT);
        end
        total++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin
            bad++;
            $display("FAIL timeout_drop got=%0d need=%0d", drop_cnt, exp_drop);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL timeout_count got=%0d need=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL timeout_word got=%h need=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_drain();
        fork
            send(1, 2, 32'h500, 32'd1, 2'd0, 1'b0, -1, 0);
            repeat (2) begin
                @(negedge clk);
                total++;
                if (dout_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL drain_vld got=%b need=0", dout_vld);
                end
            end
        join
        exp_drop += 2;
        settle();
        total++;
        if (drop_cnt !== CNT_W'(exp_drop)) begin
            bad++;
            $display("FAIL drain_drop got=%0d need=%0d", drop_cnt, exp_drop);
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL drain_output got=%0d words need=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid_packet();
        wd_t e, o;
        int st;
        st = n_out;
        push_pkt(2, 32'h600, 32'd1, 2'd0);
        exp_q[1].eop = 1'b0;
        fork
            send(0, 6, 32'h600, 32'd1, 2'd0, 1'b1, -1, 0);
            begin
                wait_out(st + 2);
                @(posedge clk);
                #2;
                rst = 1'b1;
                kill = 1'b1;
                #1;
                o = {dout, dout_sop, dout_eop, dout_mod, dout_err};
                total++;
                if (o !== '0 || dout_vld !== 1'b0) begin
                    bad++;
                    $display("FAIL midrst_dout got=%h vld=%b need=0 vld=0", o, dout_vld);
                end
                total++;
                if ({s0_din_rdy, s1_din_rdy, grant} !== 3'b001 || drop_cnt !== '0) begin
                    bad++;
                    $display("FAIL midrst_regs got rdy=%b%b grant=%b drop=%0d need rdy=00 grant=1 drop=0",
                             s0_din_rdy, s1_din_rdy, grant, drop_cnt);
                end
            end
        join
        rst = 1'b0;
        kill = 1'b0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        push_pkt(3, 32'h700, 32'd1, 2'd1);
        send(1, 3, 32'h700, 32'd1, 2'd1, 1'b1, -1, 0);
        settle();
        total++;
        if (grant !== 1'b1 || drop_cnt !== CNT_W'(exp_drop)) begin
            bad++;
            $display("FAIL midrst_after got grant=%b drop=%0d need grant=1 drop=%0d", grant, drop_cnt, exp_drop);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL midrst_count got=%0d need=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_word got=%h need=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_drain();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish need finish within 1000000 time units");
        $fatal(1, "watchdog");
    end
endmodule
